// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending/encoder slice.
package irq_pkg;

   localparam int N_REQ = 8;
   localparam int POS_W = 3;

   typedef logic [POS_W-1:0] pos_t;

   function automatic logic [N_REQ-1:0] onehot(pos_t idx);
      logic [N_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder; bit 0 has highest priority.
module prio_enc_lsb #(
   parameter int N     = 8,
   parameter int POS_W = 3
) (
   input  logic [N-1:0]     vec,
   output logic [POS_W-1:0] idx
);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = POS_W'(i);
      end
   end

endmodule

// File: rtl/irq_pending_encoder.sv
// Sticky request capture, masking, priority selection and a registered
// valid/ready index output with a saturating collision counter.
module irq_pending_encoder
   import irq_pkg::*;
#(
   parameter int N     = N_REQ,
   parameter int POS_W = irq_pkg::POS_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic [N-1:0]     req_in,
   input  logic [N-1:0]     mask,
   output logic             pos_valid,
   input  logic             pos_ready,
   output logic [POS_W-1:0] pos,
   output logic [N-1:0]     pending,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_count
);

   logic             accept;
   logic             load;
   logic [N-1:0]     clr_vec;
   logic [N-1:0]     eligible;
   logic [N-1:0]     collide;
   logic [POS_W-1:0] sel;

   assign accept   = pos_valid & pos_ready;
   assign clr_vec  = accept ? N'(onehot(pos_t'(pos))) : '0;
   // Selection sees only registered pending, never this cycle's requests.
   assign eligible = pending & ~mask & ~clr_vec;
   assign collide  = req_in & pending & ~clr_vec;
   assign load     = !pos_valid | accept;

   prio_enc_lsb #(
      .N     (N),
      .POS_W (POS_W)
   ) u_enc (
      .vec (eligible),
      .idx (sel)
   );

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         pending    <= '0;
         pos_valid  <= 1'b0;
         pos        <= '0;
         drop_pulse <= 1'b0;
         drop_count <= '0;
      end else begin
         pending    <= (pending & ~clr_vec) | req_in;
         drop_pulse <= |collide;
         if (load) begin
            pos_valid <= |eligible;
            pos       <= sel;
         end
         if (|collide && drop_count != {CNT_W{1'b1}})
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule
